// File: rtl/actuator_pkg.sv
// Shared constants and frame-state encoding for the actuator SPI register bank.
package actuator_pkg;
  localparam int ADDR_W = 7;
  localparam logic [ADDR_W-1:0] STATUS_ADDR = 7'h7F;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} frame_state_e;
endpackage

// File: rtl/actuator_spi_rx.sv
// SPI mode-0 slave front end: pin synchronisers, frame FSM and shift registers.
// ACT_READBACK_EN adds a parallel-loaded miso shifter fed from rd_addr/rd_data.
module actuator_spi_rx
  import actuator_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
`ifdef ACT_READBACK_EN
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              miso,
  output logic              miso_oe,
`endif
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int FRAME_W = 8 + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q, ss_prev_d;
  frame_state_e           state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]     shift_q, shift_d;
  logic                   wr_stb_q, wr_stb_d;

  logic sclk_s, mosi_s, ss_s;
  logic sclk_rise, ss_fall, ss_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    wr_stb_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
        end
      end
      CMD, DATA: begin
        // Deselect before the last data bit abandons the frame without a write
        if (ss_rise) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          shift_d   = {shift_q[FRAME_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_d == CNT_W'(8)) state_d = DATA;
          if (bit_cnt_d == CNT_W'(FRAME_W)) begin
            state_d  = DONE;
            wr_stb_d = shift_d[FRAME_W-1];
          end
        end
      end
      DONE: begin
        if (ss_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wr_stb_q    <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wr_stb_q    <= wr_stb_d;
    end
  end

  assign wr_stb  = wr_stb_q;
  assign wr_addr = shift_q[FRAME_W-2 -: ADDR_W];
  assign wr_data = shift_q[DATA_W-1:0];

`ifdef ACT_READBACK_EN
  logic              sclk_fall;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_load_q, rd_load_d;
  logic [DATA_W-1:0] rd_shift_q, rd_shift_d;
  logic              miso_q, miso_d;

  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // Read data is loaded one clock after the address completes, well before the first falling sclk
  always_comb begin
    rd_addr_d  = rd_addr_q;
    rd_load_d  = 1'b0;
    rd_shift_d = rd_shift_q;
    miso_d     = miso_q;
    if (state_q == CMD && state_d == DATA) begin
      rd_addr_d = shift_d[ADDR_W-1:0];
      rd_load_d = ~shift_d[ADDR_W];
    end
    if (state_q == IDLE) begin
      rd_shift_d = '0;
    end else if (rd_load_q) begin
      rd_shift_d = rd_data;
    end else if (state_q == DATA && sclk_fall) begin
      miso_d     = rd_shift_q[DATA_W-1];
      rd_shift_d = {rd_shift_q[DATA_W-2:0], 1'b0};
    end
    if (state_q == IDLE || state_q == CMD) miso_d = 1'b0;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rd_addr_q  <= '0;
      rd_load_q  <= 1'b0;
      rd_shift_q <= '0;
      miso_q     <= 1'b0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      rd_load_q  <= rd_load_d;
      rd_shift_q <= rd_shift_d;
      miso_q     <= miso_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign miso    = miso_q;
  assign miso_oe = ~ss_s;
`endif

endmodule

// File: rtl/actuator_spi_bank.sv
// SPI-loaded shadow/active timing register bank firing one-shot pulses per channel.
// Optional SPI readback of shadow registers and status under ACT_READBACK_EN.
module actuator_spi_bank
  import actuator_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              enable_n,
  input  logic              trigger_in_n,
  input  logic              latch_data_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic              miso_oe,
  output logic [NUM_CH-1:0] act_out,
  output logic              busy
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
  logic [SYNC_STAGES-1:0] trig_sync_q, trig_sync_d;
  logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
  logic                   trig_prev_q, trig_prev_d;
  logic                   latch_prev_q, latch_prev_d;
  logic [DATA_W-1:0]      shadow_q [NUM_CH];
  logic [DATA_W-1:0]      shadow_d [NUM_CH];
  logic [DATA_W-1:0]      active_q [NUM_CH];
  logic [DATA_W-1:0]      active_d [NUM_CH];
  logic [DATA_W-1:0]      cnt_q    [NUM_CH];
  logic [DATA_W-1:0]      cnt_d    [NUM_CH];

  logic              wr_stb, wr_hit;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              en_off, trig_fall, latch_fall;

  assign en_off     = en_sync_q[SYNC_STAGES-1];
  assign trig_fall  = ~trig_sync_q[SYNC_STAGES-1] & trig_prev_q;
  assign latch_fall = ~latch_sync_q[SYNC_STAGES-1] & latch_prev_q;
  assign wr_hit     = wr_stb && ({1'b0, wr_addr} < 8'(NUM_CH));

`ifdef ACT_READBACK_EN
  localparam int STAT_W = (NUM_CH + 1 > DATA_W) ? NUM_CH + 1 : DATA_W;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [STAT_W-1:0] status_wide;

  assign status_wide = STAT_W'({busy, act_out});

  always_comb begin
    rd_data = '0;
    if (rd_addr == STATUS_ADDR)
      rd_data = status_wide[DATA_W-1:0];
    else if ({1'b0, rd_addr} < 8'(NUM_CH))
      rd_data = shadow_q[rd_addr[CH_W-1:0]];
  end
`else
  assign miso    = 1'b0;
  assign miso_oe = 1'b0;
`endif

  actuator_spi_rx #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clock   (clock),
    .resetb  (resetb),
    .sclk    (sclk),
    .mosi    (mosi),
    .ss_n    (ss_n),
`ifdef ACT_READBACK_EN
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .miso    (miso),
    .miso_oe (miso_oe),
`endif
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Latch reads pre-write shadow; trigger loads from the post-latch active value
  always_comb begin
    en_sync_d    = {en_sync_q[SYNC_STAGES-2:0], enable_n};
    trig_sync_d  = {trig_sync_q[SYNC_STAGES-2:0], trigger_in_n};
    latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], latch_data_n};
    trig_prev_d  = trig_sync_q[SYNC_STAGES-1];
    latch_prev_d = latch_sync_q[SYNC_STAGES-1];
    shadow_d     = shadow_q;
    active_d     = active_q;
    cnt_d        = cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_hit && wr_addr[CH_W-1:0] == CH_W'(i)) shadow_d[i] = wr_data;
      if (latch_fall) active_d[i] = shadow_q[i];
      if (en_off)
        cnt_d[i] = '0;
      else if (trig_fall)
        cnt_d[i] = active_d[i];
      else if (cnt_q[i] != '0)
        cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      en_sync_q    <= '1;
      trig_sync_q  <= '1;
      latch_sync_q <= '1;
      trig_prev_q  <= 1'b1;
      latch_prev_q <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      en_sync_q    <= en_sync_d;
      trig_sync_q  <= trig_sync_d;
      latch_sync_q <= latch_sync_d;
      trig_prev_q  <= trig_prev_d;
      latch_prev_q <= latch_prev_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    act_out = '0;
    for (int i = 0; i < NUM_CH; i++) act_out[i] = (cnt_q[i] != '0);
  end

  assign busy = |act_out;

endmodule
